lcd_bus_ctrl: RTL and testbench

LCD_BUS_CTRL -- requirements
Module: lcd_bus_ctrl

---
 rtl/lcd_bus_pkg.sv | 20 ++
 rtl/lcd_bus_ctrl.sv | 167 ++++++++++++++++
 tb/tb_lcd_bus_ctrl.sv | 297 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lcd_bus_pkg.sv
// Shared state encoding and default timing for the LCD parallel bus controller.
package lcd_bus_pkg;

  localparam int unsigned CNT_W          = 16;
  localparam int unsigned DEF_T_SETUP    = 1;
  localparam int unsigned DEF_T_STROBE   = 2;
  localparam int unsigned DEF_T_HOLD     = 1;
  localparam int unsigned DEF_T_RST_LOW  = 200;
  localparam int unsigned DEF_T_RST_WAIT = 2400;

  typedef enum logic [2:0] {
    RST_LOW,
    RST_WAIT,
    IDLE,
    SETUP,
    STROBE,
    HOLD
  } lcd_state_e;

endpackage

// File: rtl/lcd_bus_ctrl.sv
// 8080-style LCD bus master: panel reset sequencing plus single-word
// read/write cycles with programmable setup / strobe / hold timing.
module lcd_bus_ctrl
  import lcd_bus_pkg::*;
#(
  parameter int unsigned T_SETUP    = DEF_T_SETUP,
  parameter int unsigned T_STROBE   = DEF_T_STROBE,
  parameter int unsigned T_HOLD     = DEF_T_HOLD,
  parameter int unsigned T_RST_LOW  = DEF_T_RST_LOW,
  parameter int unsigned T_RST_WAIT = DEF_T_RST_WAIT
) (
  input  logic        lcdclk,
  input  logic        lcdreset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_rs,
  input  logic        cmd_rd,
  input  logic [15:0] cmd_wdata,
  output logic        rsp_valid,
  output logic [15:0] rsp_rdata,
  input  logic        hw_reset_req,
  output logic        busy,
  output logic        lcd_reset_n,
  output logic        lcd_cs_n,
  output logic        lcd_rs,
  output logic        lcd_write_n,
  output logic        lcd_read_n,
  output logic [15:0] lcd_dout,
  output logic        lcd_doe,
  input  logic [15:0] lcd_din
);

  // Counter reload values: each phase lasts (reload + 1) cycles.
  localparam logic [CNT_W-1:0] C_SETUP    = CNT_W'(T_SETUP - 1);
  localparam logic [CNT_W-1:0] C_STROBE   = CNT_W'(T_STROBE - 1);
  localparam logic [CNT_W-1:0] C_HOLD     = CNT_W'(T_HOLD - 1);
  localparam logic [CNT_W-1:0] C_RST_LOW  = CNT_W'(T_RST_LOW - 1);
  localparam logic [CNT_W-1:0] C_RST_WAIT = CNT_W'(T_RST_WAIT - 1);

  lcd_state_e       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_pend;
  logic             r_rd;

  logic w_cnt_zero;
  logic w_rst_req;

  assign w_cnt_zero = (r_cnt == '0);
  // A request arriving this very cycle counts the same as one already latched.
  assign w_rst_req  = r_pend | hw_reset_req;
  assign cmd_ready  = (r_state == IDLE) & ~w_rst_req;
  assign busy       = (r_state != IDLE);

  // Bus/reset FSM with a shared phase counter; panel-side outputs are
  // registered and updated on the transition into each phase.
  always_ff @(posedge lcdclk or posedge lcdreset) begin
    if (lcdreset) begin
      r_state     <= RST_LOW;
      r_cnt       <= C_RST_LOW;
      r_pend      <= 1'b0;
      r_rd        <= 1'b0;
      lcd_reset_n <= 1'b0;
      lcd_cs_n    <= 1'b1;
      lcd_rs      <= 1'b0;
      lcd_write_n <= 1'b1;
      lcd_read_n  <= 1'b1;
      lcd_dout    <= '0;
      lcd_doe     <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
    end else begin
      rsp_valid <= 1'b0;
      r_pend    <= r_pend | hw_reset_req;
      case (r_state)
        RST_LOW: begin
          if (w_cnt_zero) begin
            r_state     <= RST_WAIT;
            r_cnt       <= C_RST_WAIT;
            lcd_reset_n <= 1'b1;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        RST_WAIT: begin
          if (w_cnt_zero) begin
            if (w_rst_req) begin
              // Request seen during the sequence: run it again from the top.
              r_state     <= RST_LOW;
              r_cnt       <= C_RST_LOW;
              r_pend      <= 1'b0;
              lcd_reset_n <= 1'b0;
            end else begin
              r_state <= IDLE;
            end
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        IDLE: begin
          if (w_rst_req) begin
            r_state     <= RST_LOW;
            r_cnt       <= C_RST_LOW;
            r_pend      <= 1'b0;
            lcd_reset_n <= 1'b0;
          end else if (cmd_valid) begin
            // lcd_rs / lcd_dout double as the latched command fields.
            r_state  <= SETUP;
            r_cnt    <= C_SETUP;
            r_rd     <= cmd_rd;
            lcd_cs_n <= 1'b0;
            lcd_rs   <= cmd_rs;
            lcd_doe  <= ~cmd_rd;
            lcd_dout <= cmd_rd ? '0 : cmd_wdata;
          end
        end
        SETUP: begin
          if (w_cnt_zero) begin
            r_state     <= STROBE;
            r_cnt       <= C_STROBE;
            lcd_write_n <= r_rd;
            lcd_read_n  <= ~r_rd;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        STROBE: begin
          if (w_cnt_zero) begin
            r_state     <= HOLD;
            r_cnt       <= C_HOLD;
            lcd_write_n <= 1'b1;
            lcd_read_n  <= 1'b1;
            if (r_rd) begin
              rsp_rdata <= lcd_din;
              rsp_valid <= 1'b1;
            end
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        HOLD: begin
          if (w_cnt_zero) begin
            lcd_cs_n <= 1'b1;
            lcd_rs   <= 1'b0;
            lcd_doe  <= 1'b0;
            lcd_dout <= '0;
            if (w_rst_req) begin
              r_state     <= RST_LOW;
              r_cnt       <= C_RST_LOW;
              r_pend      <= 1'b0;
              lcd_reset_n <= 1'b0;
            end else begin
              r_state <= IDLE;
            end
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        default: begin
          r_state     <= RST_LOW;
          r_cnt       <= C_RST_LOW;
          lcd_reset_n <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_bus_ctrl.sv
// Self-checking bench for lcd_bus_ctrl: expected waveforms are derived from
// phase lengths (setup/strobe/hold, reset low/wait) relative to acceptance.
module tb_lcd_bus_ctrl;

  localparam int TS  = 1;
  localparam int TST = 2;
  localparam int TH  = 1;
  localparam int TRL = 4;
  localparam int TRW = 8;
  localparam int L   = TS + TST + TH;   // cycles with cs_n low
  localparam int JV  = TS + TST + 1;    // first hold cycle (rsp_valid)

  logic        lcdclk = 1'b0;
  logic        lcdreset = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_rs = 1'b0;
  logic        cmd_rd = 1'b0;
  logic [15:0] cmd_wdata = '0;
  logic        rsp_valid;
  logic [15:0] rsp_rdata;
  logic        hw_reset_req = 1'b0;
  logic        busy;
  logic        lcd_reset_n;
  logic        lcd_cs_n;
  logic        lcd_rs;
  logic        lcd_write_n;
  logic        lcd_read_n;
  logic [15:0] lcd_dout;
  logic        lcd_doe;
  logic [15:0] lcd_din = '0;

  int errors = 0;
  int checks = 0;
  logic [15:0] last_rd = '0;

  lcd_bus_ctrl #(
    .T_SETUP(TS), .T_STROBE(TST), .T_HOLD(TH), .T_RST_LOW(TRL), .T_RST_WAIT(TRW)
  ) dut (
    .lcdclk(lcdclk), .lcdreset(lcdreset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_rs(cmd_rs), .cmd_rd(cmd_rd),
    .cmd_wdata(cmd_wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .hw_reset_req(hw_reset_req), .busy(busy),
    .lcd_reset_n(lcd_reset_n), .lcd_cs_n(lcd_cs_n), .lcd_rs(lcd_rs),
    .lcd_write_n(lcd_write_n), .lcd_read_n(lcd_read_n),
    .lcd_dout(lcd_dout), .lcd_doe(lcd_doe), .lcd_din(lcd_din)
  );

  always #5 lcdclk = ~lcdclk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reset sequence check; the current sample is the first RST_LOW cycle.
  task automatic expect_reset_seq(input string tag);
    logic [6:0] obs, exp;
    for (int i = 0; i <= TRL + TRW; i++) begin
      if (i > 0) @(negedge lcdclk);
      obs = {lcd_reset_n, lcd_cs_n, lcd_write_n, lcd_read_n, lcd_doe, cmd_ready, busy};
      exp = {i >= TRL, 1'b1, 1'b1, 1'b1, 1'b0, i >= TRL + TRW, i < TRL + TRW};
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL %s_seq i=%0d got=%b want=%b (rstn,cs,wr,rd,doe,rdy,busy)", tag, i, obs, exp);
      end
    end
  endtask

  task automatic wait_ready(output bit ok);
    int n = 0;
    while (cmd_ready !== 1'b1 && n < 100) begin
      @(negedge lcdclk);
      n++;
    end
    ok = (cmd_ready === 1'b1);
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL wait_ready timeout got=%b want=1", cmd_ready);
    end
  endtask

  // One transaction from acceptance to the return to IDLE (or, with inj,
  // a hw_reset_req pulse during the first strobe cycle).
  task automatic run_txn(input bit rd, input bit rs, input logic [15:0] data,
                         input logic [15:0] din, input bit inj);
    bit ok;
    logic [6:0]  obs, exp;
    logic [16:0] obs2, exp2;
    logic [15:0] exp_rdata;
    wait_ready(ok);
    if (!ok) return;
    cmd_valid = 1'b1; cmd_rd = rd; cmd_rs = rs; cmd_wdata = data;
    lcd_din = ~din;
    for (int j = 1; j <= L + 1; j++) begin
      @(negedge lcdclk);
      obs = {lcd_cs_n, lcd_write_n, lcd_read_n, lcd_doe, rsp_valid, cmd_ready, busy};
      exp = {!(j <= L),
             !(!rd && j > TS && j <= TS + TST),
             !(rd && j > TS && j <= TS + TST),
             !rd && j <= L,
             rd && j == JV,
             (j == L + 1) && !inj,
             (j <= L) || inj};
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL txn_ctl rd=%0d j=%0d got=%b want=%b (cs,wr,rd,doe,rv,rdy,busy)", rd, j, obs, exp);
      end
      if (j <= L) begin
        obs2 = {lcd_rs, rd ? 16'h0000 : lcd_dout};
        exp2 = {rs, rd ? 16'h0000 : data};
        checks++;
        if (obs2 !== exp2) begin
          errors++;
          $display("FAIL txn_rs_dout j=%0d got=%h want=%h", j, obs2, exp2);
        end
      end
      exp_rdata = (rd && j >= JV) ? din : last_rd;
      checks++;
      if (rsp_rdata !== exp_rdata) begin
        errors++;
        $display("FAIL txn_rdata j=%0d got=%h want=%h", j, rsp_rdata, exp_rdata);
      end
      // Disturb inputs after acceptance to prove the fields were latched.
      if (j == 1) begin
        cmd_valid = 1'b0; cmd_rd = ~rd; cmd_rs = ~rs; cmd_wdata = 16'($urandom);
      end
      hw_reset_req = inj && (j == TS + 1);
      if (j == TS + TST) lcd_din = din;
      if (j == JV) lcd_din = 16'($urandom);
    end
    hw_reset_req = 1'b0;
    if (rd) last_rd = din;
  endtask

  task automatic test_reset();
    @(negedge lcdclk);
    checks++;
    if ({lcd_reset_n, lcd_cs_n, lcd_write_n, lcd_read_n, lcd_doe, lcd_rs, cmd_ready, rsp_valid, busy} !== 9'b0_1110_0001) begin
      errors++;
      $display("FAIL reset_ctl got=%b want=011100001",
               {lcd_reset_n, lcd_cs_n, lcd_write_n, lcd_read_n, lcd_doe, lcd_rs, cmd_ready, rsp_valid, busy});
    end
    checks++;
    if ({lcd_dout, rsp_rdata} !== 32'h0) begin
      errors++;
      $display("FAIL reset_data got=%h want=0", {lcd_dout, rsp_rdata});
    end
    @(negedge lcdclk);
    lcdreset = 1'b0;
    expect_reset_seq("reset");
  endtask

  task automatic test_write();
    run_txn(1'b0, 1'b1, 16'hA5C3, 16'h0000, 1'b0);
  endtask

  task automatic test_read();
    run_txn(1'b1, 1'b1, 16'h0000, 16'h1234, 1'b0);
  endtask

  task automatic test_random();
    for (int k = 0; k < 24; k++) begin
      run_txn(1'($urandom), 1'($urandom), 16'($urandom), 16'($urandom), 1'b0);
      repeat ($urandom_range(0, 2)) @(negedge lcdclk);
    end
  endtask

  task automatic test_back_to_back();
    bit ok, done;
    int t, acc, csh;
    int at [3];
    logic [15:0] d [3];
    for (int k = 0; k < 3; k++) d[k] = 16'($urandom);
    wait_ready(ok);
    if (!ok) return;
    cmd_valid = 1'b1; cmd_rd = 1'b0; cmd_rs = 1'b0; cmd_wdata = d[0];
    t = 0; acc = 0; csh = 0; done = 0;
    while (!done && t < 60) begin
      if (acc >= 1 && acc < 3 && lcd_cs_n === 1'b1) csh++;
      if (cmd_ready === 1'b1 && cmd_valid) begin
        at[acc] = t;
        acc++;
      end else if (acc > 0 && t == at[acc-1] + 1) begin
        checks++;
        if (lcd_dout !== d[acc-1]) begin
          errors++;
          $display("FAIL b2b_dout n=%0d got=%h want=%h", acc - 1, lcd_dout, d[acc-1]);
        end
        if (acc < 3) cmd_wdata = d[acc];
        else begin
          cmd_valid = 1'b0;
          done = 1;
        end
      end
      if (!done) begin
        @(negedge lcdclk);
        t++;
      end
    end
    cmd_valid = 1'b0;
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL b2b_timeout accepted=%0d want=3", acc);
      return;
    end
    checks++;
    if (at[1] - at[0] != L + 1) begin
      errors++;
      $display("FAIL b2b_gap01 got=%0d want=%0d", at[1] - at[0], L + 1);
    end
    checks++;
    if (at[2] - at[1] != L + 1) begin
      errors++;
      $display("FAIL b2b_gap12 got=%0d want=%0d", at[2] - at[1], L + 1);
    end
    checks++;
    if (csh != 2) begin
      errors++;
      $display("FAIL b2b_cs_high got=%0d want=2", csh);
    end
  endtask

  task automatic test_hwreq_strobe();
    run_txn(1'b0, 1'b0, 16'h5A3C, 16'h0000, 1'b1);
    expect_reset_seq("hwreq_strobe");
  endtask

  task automatic test_hwreq_idle();
    bit ok;
    wait_ready(ok);
    if (!ok) return;
    cmd_valid = 1'b1; cmd_rd = 1'b0; cmd_wdata = 16'hBEEF; hw_reset_req = 1'b1;
    #1;
    checks++;
    if (cmd_ready !== 1'b0) begin
      errors++;
      $display("FAIL hwreq_idle_ready got=%b want=0", cmd_ready);
    end
    @(negedge lcdclk);
    cmd_valid = 1'b0; hw_reset_req = 1'b0;
    expect_reset_seq("hwreq_idle");
  endtask

  task automatic test_async_reset();
    bit ok;
    logic [7:0] obs;
    wait_ready(ok);
    if (!ok) return;
    cmd_valid = 1'b1; cmd_rd = 1'b0; cmd_rs = 1'b1; cmd_wdata = 16'hC0DE;
    @(negedge lcdclk);
    cmd_valid = 1'b0;
    @(negedge lcdclk);
    checks++;
    if (lcd_write_n !== 1'b0) begin
      errors++;
      $display("FAIL async_pre_strobe got=%b want=0", lcd_write_n);
    end
    #2 lcdreset = 1'b1;
    #1;
    obs = {lcd_cs_n, lcd_write_n, lcd_read_n, lcd_doe, lcd_reset_n, cmd_ready, busy, rsp_valid};
    checks++;
    if (obs !== 8'b1110_0010) begin
      errors++;
      $display("FAIL async_outputs got=%b want=11100010", obs);
    end
    checks++;
    if ({lcd_dout, rsp_rdata, lcd_rs} !== 33'h0) begin
      errors++;
      $display("FAIL async_data got=%h want=0", {lcd_dout, rsp_rdata, lcd_rs});
    end
    last_rd = '0;
    repeat (2) @(negedge lcdclk);
    lcdreset = 1'b0;
    expect_reset_seq("async");
    run_txn(1'b1, 1'b0, 16'h0000, 16'h9ABC, 1'b0);
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_random();
    test_back_to_back();
    test_hwreq_strobe();
    test_hwreq_idle();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
